// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM read/write port among
// NUM_REQ requesters that each use a level read/write + finished handshake.
// One access at a time: IDLE -> ACCESS (strobe held) -> RESP (one-cycle pulse).
// A watchdog turns an access the SDRAM never completes into an error response.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_finished,
  output logic                      req_error,
  output logic                      sdram_read,
  output logic                      sdram_write,
  output logic [ADDR_W-1:0]         sdram_addr,
  output logic [DATA_W-1:0]         sdram_writedata,
  input  logic [DATA_W-1:0]         sdram_readdata,
  input  logic                      sdram_finished
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant;
  logic [TW-1:0]       wdog;

  logic                found;
  logic [GW-1:0]       win;
  logic [GW-1:0]       idx;
  logic                win_read;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [NUM_REQ-1:0]  grant_onehot;

  // Round-robin search: first active requester after the last one granted.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    found = 1'b0;
    win   = last_grant;
    idx   = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && (req_read[idx] || req_write[idx])) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's operation and operands; read takes precedence when both are set.
  always_comb begin
    win_read     = req_read[win];
    win_addr     = req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_wdata    = req_writedata[int'(win)*DATA_W +: DATA_W];
    grant_onehot = NUM_REQ'(1) << grant;
  end

  // Access FSM with all outputs registered; reset aborts any access silently.
  always_ff @(posedge i_clk) begin
    // NOTE: state and outputs use non-blocking assignments so every register
    // updates from the values present before the edge, independent of order.
    if (i_rst) begin
      state           <= IDLE;
      last_grant      <= GW'(NUM_REQ-1);
      grant           <= '0;
      wdog            <= '0;
      req_readdata    <= '0;
      req_finished    <= '0;
      req_error       <= 1'b0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_finished <= '0;
          req_error    <= 1'b0;
          wdog         <= '0;
          if (found) begin
            grant           <= win;
            last_grant      <= win;
            sdram_addr      <= win_addr;
            // Reads never expose the requester's write data on the SDRAM bus.
            sdram_writedata <= win_read ? '0 : win_wdata;
            sdram_read      <= win_read;
            sdram_write     <= !win_read;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (sdram_finished) begin
            // Completion on the final watchdog cycle still counts as success.
            if (sdram_read) req_readdata <= sdram_readdata;
            sdram_read   <= 1'b0;
            sdram_write  <= 1'b0;
            req_finished <= grant_onehot;
            req_error    <= 1'b0;
            state        <= RESP;
          end else if (wdog == TW'(TIMEOUT-1)) begin
            sdram_read   <= 1'b0;
            sdram_write  <= 1'b0;
            req_finished <= grant_onehot;
            req_error    <= 1'b1;
            req_readdata <= '0;
            state        <= RESP;
          end else begin
            wdog <= wdog + TW'(1);
          end
        end
        RESP: begin
          req_finished <= '0;
          req_error    <= 1'b0;
          wdog         <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter. Requester processes
// replay job queues with the level handshake; a monitor acting as the SDRAM
// model predicts grants by the round-robin rule and pushes expected responses,
// and a separate completion monitor pops and compares on each req_finished.
module tb_sdram_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      i_rst = 1'b1;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_finished;
  logic                      req_error;
  logic                      sdram_read;
  logic                      sdram_write;
  logic [ADDR_W-1:0]         sdram_addr;
  logic [DATA_W-1:0]         sdram_writedata;
  logic [DATA_W-1:0]         sdram_readdata;
  logic                      sdram_finished;

  // Per-requester drive values, packed onto the DUT buses.
  logic              r_rd   [NUM_REQ];
  logic              r_wr   [NUM_REQ];
  logic [ADDR_W-1:0] r_addr [NUM_REQ];
  logic [DATA_W-1:0] r_wdata[NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_pack
    assign req_read[k]                          = r_rd[k];
    assign req_write[k]                         = r_wr[k];
    assign req_addr[k*ADDR_W +: ADDR_W]         = r_addr[k];
    assign req_writedata[k*DATA_W +: DATA_W]    = r_wdata[k];
  end

  sdram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_finished(req_finished), .req_error(req_error),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr2;
    logic              chg;
    logic [DATA_W-1:0] wdata;
  } job_t;

  typedef struct {
    logic [NUM_REQ-1:0] fin;
    logic               err;
    logic [DATA_W-1:0]  data;
  } resp_t;

  typedef enum {M_ARB, M_ACC, M_IDLE_NEXT} mphase_t;

  job_t    jq[NUM_REQ][$];
  resp_t   cq[$];
  int      n_cmp = 0;
  int      n_fail = 0;

  // SDRAM behaviour knobs: cfg_lat = strobe cycles until finished (0 = never,
  // negative = random per access); cfg_fixed forces the returned read data.
  int          cfg_lat = 4;
  logic        cfg_fixed = 1'b0;
  logic [DATA_W-1:0] cfg_data = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Requester inputs as seen by the DUT at each rising edge.
  logic [NUM_REQ-1:0] s_act, s_rd;
  logic [ADDR_W-1:0]  s_addr [NUM_REQ];
  logic [DATA_W-1:0]  s_wdata[NUM_REQ];
  logic               s_rst = 1'b0;

  initial forever begin
    @(posedge clk);
    s_rst = i_rst;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_act[k]   = r_rd[k] | r_wr[k];
      s_rd[k]    = r_rd[k];
      s_addr[k]  = r_addr[k];
      s_wdata[k] = r_wdata[k];
    end
  end

  // Reference model / SDRAM responder state.
  mphase_t           mphase = M_ARB;
  int                ptr = NUM_REQ - 1;
  int                mw, mk;
  int                acc_lat, acc_cnt;
  logic              acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_data;
  logic [DATA_W-1:0] last_rd = '0;
  resp_t             exp_r;

  task automatic check_strobe();
    check("strobe_read",  64'(sdram_read),  64'(acc_rd));
    check("strobe_write", 64'(sdram_write), 64'(!acc_rd));
    check("sdram_addr",   64'(sdram_addr),  64'(acc_addr));
    if (!acc_rd) check("sdram_wdata", 64'(sdram_writedata), 64'(acc_wdata));
  endtask

  task automatic drive_finished();
    if (acc_cnt == acc_lat) begin
      sdram_finished = 1'b1;
      sdram_readdata = acc_data;
    end
  endtask

  // Monitor + SDRAM model: predicts each grant and the access timing.
  initial begin
    sdram_finished = 1'b0;
    sdram_readdata = '0;
    forever begin
      @(negedge clk);
      sdram_finished = 1'b0;
      sdram_readdata = DATA_W'($urandom);
      if (s_rst) begin
        check("rst_read",     64'(sdram_read),      64'(0));
        check("rst_write",    64'(sdram_write),     64'(0));
        check("rst_finished", 64'(req_finished),    64'(0));
        check("rst_error",    64'(req_error),       64'(0));
        check("rst_rdata",    64'(req_readdata),    64'(0));
        check("rst_addr",     64'(sdram_addr),      64'(0));
        check("rst_wdata",    64'(sdram_writedata), 64'(0));
        cq.delete();
        ptr     = NUM_REQ - 1;
        last_rd = '0;
        mphase  = M_ARB;
      end else begin
        case (mphase)
          M_ARB: begin
            if (s_act != '0) begin
              mw = -1;
              for (int i = 1; i <= NUM_REQ; i++) begin
                mk = (ptr + i) % NUM_REQ;
                if (mw < 0 && s_act[mk]) mw = mk;
              end
              ptr       = mw;
              acc_rd    = s_rd[mw];
              acc_addr  = s_addr[mw];
              acc_wdata = s_wdata[mw];
              if (cfg_lat >= 0) acc_lat = cfg_lat;
              else acc_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
              acc_data  = cfg_fixed ? cfg_data : DATA_W'($urandom);
              exp_r.fin = NUM_REQ'(1) << mw;
              exp_r.err = (acc_lat == 0);
              exp_r.data = exp_r.err ? '0 : (acc_rd ? acc_data : last_rd);
              last_rd   = exp_r.data;
              cq.push_back(exp_r);
              acc_cnt   = 1;
              check_strobe();
              drive_finished();
              mphase = M_ACC;
            end else begin
              check("idle_read",  64'(sdram_read),  64'(0));
              check("idle_write", 64'(sdram_write), 64'(0));
            end
          end
          M_ACC: begin
            if (acc_cnt == acc_lat || acc_cnt == TIMEOUT) begin
              check("resp_read",  64'(sdram_read),  64'(0));
              check("resp_write", 64'(sdram_write), 64'(0));
              check("resp_pulse", 64'(req_finished != '0), 64'(1));
              mphase = M_IDLE_NEXT;
            end else begin
              acc_cnt++;
              check_strobe();
              drive_finished();
            end
          end
          default: begin
            check("post_read",     64'(sdram_read),   64'(0));
            check("post_write",    64'(sdram_write),  64'(0));
            check("post_finished", 64'(req_finished), 64'(0));
            mphase = M_ARB;
          end
        endcase
      end
    end
  end

  // Completion monitor: pops the expected response on every finished pulse.
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (!s_rst && req_finished != '0) begin
      if (cq.size() == 0) begin
        check("finished_unexpected", 64'(req_finished), 64'(0));
      end else begin
        r = cq.pop_front();
        check("finished_vec", 64'(req_finished), 64'(r.fin));
        check("error_flag",   64'(req_error),    64'(r.err));
        check("readdata",     64'(req_readdata), 64'(r.data));
      end
    end
  end

  // One requester: hold each job until its own finished pulse, then move on.
  task automatic requester(int k);
    job_t j;
    logic got;
    r_rd[k] = 1'b0; r_wr[k] = 1'b0; r_addr[k] = '0; r_wdata[k] = '0;
    forever begin
      if (jq[k].size() == 0) begin
        r_rd[k] = 1'b0;
        r_wr[k] = 1'b0;
        @(negedge clk);
      end else begin
        j = jq[k].pop_front();
        r_rd[k] = j.rd; r_wr[k] = j.wr; r_addr[k] = j.addr; r_wdata[k] = j.wdata;
        got = 1'b0;
        for (int cnt = 1; cnt <= 300 && !got; cnt++) begin
          @(negedge clk);
          if (j.chg && cnt == 3) r_addr[k] = j.addr2;
          if (req_finished[k]) got = 1'b1;
        end
        if (!got) bound_fail("requester_wait");
      end
    end
  endtask

  task automatic push_job(int k, logic rd, logic wr, logic [ADDR_W-1:0] a,
                          logic [DATA_W-1:0] d, logic chg = 1'b0,
                          logic [ADDR_W-1:0] a2 = '0);
    job_t j;
    j.rd = rd; j.wr = wr; j.addr = a; j.wdata = d; j.chg = chg; j.addr2 = a2;
    jq[k].push_back(j);
  endtask

  task automatic wait_quiet();
    int  calm = 0;
    logic busy;
    for (int n = 0; n < 3000 && calm < 3; n++) begin
      @(negedge clk);
      busy = sdram_read | sdram_write | (mphase != M_ARB);
      for (int k = 0; k < NUM_REQ; k++)
        if (jq[k].size() != 0 || r_rd[k] || r_wr[k]) busy = 1'b1;
      calm = busy ? 0 : calm + 1;
    end
    if (calm < 3) bound_fail("wait_quiet");
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < NUM_REQ; k++) begin
      fork
        automatic int kk = k;
        requester(kk);
      join_none
    end
    repeat (3) @(negedge clk);
    i_rst = 1'b0;

    // Single read returning fixed data after 4 strobe cycles.
    @(posedge clk);
    cfg_fixed = 1'b1; cfg_data = 32'hDEADBEEF; cfg_lat = 4;
    push_job(1, 1'b1, 1'b0, 23'h001234, 32'h0);
    wait_quiet();
    cfg_fixed = 1'b0;

    // Three simultaneous writers, each re-requesting immediately.
    @(posedge clk);
    cfg_lat = 2;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_REQ; k++)
        push_job(k, 1'b0, 1'b1, ADDR_W'(32'h10 + k), DATA_W'(32'hA0 + k));
    wait_quiet();

    // Read and write both high: treated as a read.
    @(posedge clk);
    cfg_lat = 3;
    push_job(2, 1'b1, 1'b1, 23'h000077, 32'h5555AAAA);
    wait_quiet();

    // Watchdog: never finished, then finished on the last allowed cycle.
    @(posedge clk);
    cfg_lat = 0;
    push_job(0, 1'b1, 1'b0, 23'h000100, 32'h0);
    wait_quiet();
    @(posedge clk);
    cfg_lat = TIMEOUT;
    push_job(0, 1'b1, 1'b0, 23'h000101, 32'h0);
    wait_quiet();

    // Reset during an access, with a second requester pending.
    @(posedge clk);
    cfg_lat = 6;
    push_job(1, 1'b1, 1'b0, 23'h000040, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (sdram_read) seen = 1'b1;
    end
    if (!seen) bound_fail("strobe_before_reset");
    @(posedge clk);
    push_job(2, 1'b1, 1'b0, 23'h000050, 32'h0);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    wait_quiet();

    // Address changes mid-access.
    @(posedge clk);
    cfg_lat = 6;
    push_job(0, 1'b1, 1'b0, 23'h000020, 32'h0, 1'b1, 23'h000030);
    wait_quiet();

    // Randomized traffic with random latencies and occasional timeouts.
    cfg_lat = -1;
    for (int n = 0; n < 45; n++) begin
      int   k;
      logic rd, wr;
      @(posedge clk);
      k  = int'($urandom_range(0, NUM_REQ - 1));
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      push_job(k, rd, wr, ADDR_W'($urandom), DATA_W'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM read/write port between audio cores, for example recorder, player and pitch core.
- Each requester uses the same level handshake toward the arbiter that the SDRAM port uses: hold read or write with a stable address and data until a finished pulse.
- The arbiter grants one access at a time using round-robin priority, forwards that access to SDRAM, and returns the result to the granted requester.
- A watchdog aborts accesses the SDRAM never completes.

Parameters:
- NUM_REQ, 3: number of requesters; requester 0 is highest priority after reset.
- ADDR_W, 23: SDRAM word address width.
- DATA_W, 32: data width.
- TIMEOUT, 1024: max cycles in ACCESS before abort; must be ≥ 2.

Ports:
- i_clk  in  1  system clock. One clock only.
- i_rst  in  1  reset; synchronous, active-high.
- req_read  in  NUM_REQ  per-requester read request (level).
- req_write  in  NUM_REQ  per-requester write request (level).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_writedata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_readdata  out  DATA_W  read data, broadcast to all requesters.
- req_finished  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_error  out  1  one-cycle pulse, coincident with req_finished, when the access timed out.
- sdram_read  out  1  read strobe to SDRAM controller.
- sdram_write  out  1  write strobe to SDRAM controller.
- sdram_addr  out  ADDR_W  SDRAM address.
- sdram_writedata  out  DATA_W  SDRAM write data.
- sdram_readdata  in  DATA_W  SDRAM read data; valid while sdram_finished=1.
- sdram_finished  in  1  SDRAM access complete.

Behaviour:
- All outputs are registered.
- Reset values:
  - All outputs 0; state IDLE; watchdog counter 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 is searched first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - A requester is active if req_read[k] | req_write[k].
  - Search order: last_grant+1, last_grant+2, … modulo NUM_REQ.
  - The first active requester g wins. On that edge:
    - latch g, op, req_addr[g] and req_writedata[g];
    - last_grant <= g;
    - state <= ACCESS.
  - If both req_read[g] and req_write[g] are high, the operation is a read; the write is ignored.
  - If no requester is active, stay in IDLE.
- ACCESS:
  - sdram_read or sdram_write is held high, never both.
  - sdram_addr and sdram_writedata are driven from the latched values.
  - Requester inputs are ignored, so a requester changing its address mid-access has no effect.
  - The watchdog increments every cycle.
  - On sdram_finished=1: latch sdram_readdata into req_readdata (reads only; writes leave it unchanged) and go to RESP.
  - If the watchdog reaches TIMEOUT-1 with no sdram_finished, go to RESP with the error flag set.
  - If sdram_finished arrives on that same final cycle, it counts as success.
- RESP (exactly one cycle):
  - sdram_read/write = 0.
  - req_finished[g] = 1; req_error = the error flag.
  - On error, req_readdata = 0.
  - Next state is IDLE; the watchdog is cleared.
- Timing:
  - Request first seen in IDLE at cycle c → SDRAM strobe high at c+1.
  - sdram_finished at cycle d → strobe low and req_finished high at d+1 → IDLE at d+2.
  - Minimum turnaround is 3 cycles per access.
- Requester contract:
  - Deassert the request on the edge that samples req_finished=1, so it is low by the next IDLE cycle.
  - A request still high in that IDLE cycle is treated as a new access; it is not an error.
- sdram_finished is ignored in IDLE and RESP.
- Fairness:
  - A requester with a continuous request is granted within NUM_REQ grants.
  - The previously granted requester has the lowest priority at the next arbitration.
- Reset mid-operation (any state):
  - Return to IDLE on the next edge; strobes drop immediately.
  - No req_finished is issued for the aborted access; the pointer is reset.

Test Plan:
1. Reset, then requester 1 reads address 0x00_1234; SDRAM returns 0xDEADBEEF with sdram_finished at 4 cycles after the strobe → sdram_read high from c+1 for 4 cycles, sdram_addr=0x001234, req_finished=3'b010 pulse with req_readdata=0xDEADBEEF, req_error=0.
2. Requesters 0, 1 and 2 all write simultaneously (data 0xA0, 0xA1, 0xA2 at addresses 0x10, 0x11, 0x12), each held until its own finished pulse, then re-requested immediately → SDRAM sees writes in order 0, 1, 2, 0, 1, 2 with matching address and data; each finished pulse goes only to its own requester.
3. Requester 2 holds req_read and req_write both high → only sdram_read is asserted; req_writedata is never observed on SDRAM.
4. TIMEOUT=8; requester 0 reads and sdram_finished is never asserted → sdram_read is high for exactly 8 cycles, then req_finished[0]=1 with req_error=1 and req_readdata=0, then IDLE.
5. i_rst is pulsed during ACCESS of requester 1 → on the next edge sdram_read=sdram_write=0 and no req_finished; after reset, with requesters 1 and 2 pending, requester 1 is granted first (pointer reset).
6. Requester 0 changes req_addr mid-ACCESS from 0x20 to 0x30 → sdram_addr stays 0x20 until RESP.
